serial_to_word: RTL and testbench
=================================

Name: serial_to_word

Overview:
- Bit-serial to parallel deserializer: accepts one bit per handshake and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output port, with a registered any-bit-set flag.
- Inverse of the word-to-bit reduction path; sits between a single-bit link and word-wide datapath logic.
- Independent shift and output registers allow the next word to fill while the current word waits.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising clock edge.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle; a transfer occurs when in_valid && in_ready.
- out_data  output  WIDTH  completed word; held stable while out_valid && !out_ready.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes the word; a transfer occurs when out_valid && out_ready.
- out_any  output  1  registered OR-reduction of out_data; updates in the same cycle as out_data.
- bit_count  output  $clog2(WIDTH)  number of bits held in the partial word.

Behaviour:
- Reset (reset_n=0 at a clock edge): shift register=0, bit_count=0, out_data=0, out_valid=0, out_any=0. in_ready reads 1 after the reset edge.
- Reset mid-word discards the partial bits. Reset with out_valid=1 drops the pending word.
- Input-side state is bit_count, from 0 to WIDTH-1.
- Each input transfer shifts in_bit in:
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit WIDTH-1.
- Input transfer with bit_count < WIDTH-1: bit_count increments.
- Input transfer with bit_count == WIDTH-1 (completing bit):
  - out_data takes the completed word (including this bit) on the same edge.
  - out_valid=1, out_any=|word, bit_count wraps to 0.
  - Latency: word visible on the cycle after the last bit is accepted.
- Output-side FSM:
  - EMPTY (out_valid=0) -> FULL on a completing input transfer.
  - FULL -> EMPTY on an output transfer with no completing input transfer in the same cycle.
  - FULL -> FULL when an output transfer and a completing input transfer coincide: the new word replaces the old one, out_valid stays 1, no bubble.
- in_ready = !(bit_count == WIDTH-1 && out_valid && !out_ready). This is combinational from registered state and out_ready; there is no in_valid -> in_ready path.
  - Bits 0..WIDTH-2 are always accepted.
  - Only the completing bit stalls, and only while an unconsumed word is pending.
- in_valid=1 with in_ready=0: no state change. The source holds in_bit.
- in_valid=0: no shift, bit_count holds. Gaps between bits are allowed at any position.
- out_data and out_any change only on a completing input transfer or on reset.
- After an output transfer with no new word, out_data keeps its old value; only out_valid drops.
- Sustained rate with out_ready=1: one word every WIDTH cycles, zero idle cycles.

Decomposition:
- Shared package serial_pkg: DEFAULT_WIDTH=8; out_state_t enum {OUT_EMPTY, OUT_FULL}; function count_w(width) returning $clog2(width).
- One sub-module, shift_in_reg: a WIDTH-wide shift register with enable, direction parameter and synchronous active-low clear, exposing the next-word value.
- Top level holds bit_count, the output FSM, in_ready logic and the out_any register.

Test Plan:
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> one cycle after the 8th bit, out_data=0xA5, out_valid=1, out_any=1; bit_count=0.
- LSB-first plus zero flag:
  - MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> out_data=0xA5.
  - Then eight 0 bits -> out_data=0x00, out_any=0.
- Backpressure:
  - Word 0x3C completes with out_ready=0; the next 7 bits of 0xFF are accepted.
  - in_ready=0 on the 8th bit while out_data stays 0x3C.
  - Assert out_ready -> 0x3C transfers; the 8th bit is accepted that cycle; out_data=0xFF the next cycle, out_valid never drops.
- Gapped input: bits of 0x81 with in_valid deasserted for 3 cycles after bits 2 and 6 -> bit_count holds during gaps; out_data=0x81 exactly once.
- Reset mid-word: 5 bits shifted in, then reset_n=0 for one cycle -> bit_count=0, out_valid=0, out_data=0; the following 8 bits 0x5A yield exactly 0x5A.
- Back-to-back: words 0x01, 0x80, 0xFF streamed continuously with out_ready=1 -> three output transfers spaced exactly 8 cycles apart; in_ready constantly 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial to word deserializer.
package serial_pkg;

  // Default word width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Output-side occupancy: EMPTY has no pending word, FULL holds one unconsumed word.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Width of the partial-word bit counter for a given word width.
  function automatic int count_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// WIDTH-wide serial-in shift register with enable, selectable shift direction
// and synchronous active-low clear. Exposes the word it would hold after the
// next shift so the caller can capture a completed word on the same edge.
module shift_in_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             in_bit,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] shift_reg;

  // Next-word value: the current contents shifted by one with in_bit inserted.
  // MSB-first shifts left and inserts at bit 0 so the first bit ends at the top;
  // LSB-first shifts right and inserts at the top so the first bit ends at bit 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        word_next = (shift_reg << 1) | {{(WIDTH-1){1'b0}}, in_bit};
      end
    end else begin : g_lsb_first
      always_comb begin
        word_next = (shift_reg >> 1) | {in_bit, {(WIDTH-1){1'b0}}};
      end
    end
  endgenerate

  // Shift on every accepted bit; clear on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= word_next;
    end
  end

endmodule

// File: rtl/serial_to_word.sv
// Bit-serial to parallel deserializer. Assembles WIDTH bits into a word and
// presents it on a valid/ready port with a registered any-bit-set flag. The
// shift register and the output register are independent, so the next word
// fills while the current one waits; only the completing bit can stall.
module serial_to_word
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_any,
  output logic [count_w(WIDTH)-1:0]  bit_count
);

  localparam int            CW        = count_w(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH - 1);

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_any_reg;
  logic [WIDTH-1:0] word_next;
  out_state_t       state_reg;
  out_state_t       state_next;

  logic last_bit;
  logic in_xfer;
  logic word_done;
  logic out_xfer;

  assign last_bit  = (count_reg == COUNT_MAX);
  // The completing bit waits only while an unconsumed word is still pending.
  assign in_ready  = !(last_bit && out_valid && !out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign word_done = in_xfer && last_bit;
  assign out_xfer  = out_valid && out_ready;

  shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (in_xfer),
    .in_bit    (in_bit),
    .word_next (word_next)
  );

  // Partial-word bit counter: counts accepted bits and wraps on the completing bit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (in_xfer) begin
      count_reg <= last_bit ? '0 : count_reg + COUNT_ONE;
    end
  end

  // Output word and its any-bit-set flag load together when a word completes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_data_reg <= '0;
      out_any_reg  <= 1'b0;
    end else if (word_done) begin
      out_data_reg <= word_next;
      out_any_reg  <= |word_next;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output FSM next state: a completing word always leaves us FULL, so a
  // simultaneous drain and refill keeps out_valid high with no bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OUT_EMPTY: if (word_done)              state_next = OUT_FULL;
      OUT_FULL:  if (out_xfer && !word_done) state_next = OUT_EMPTY;
      default:                               state_next = OUT_EMPTY;
    endcase
  end

  // Output FSM outputs.
  always_comb begin
    out_valid = (state_reg == OUT_FULL);
  end

  assign out_data  = out_data_reg;
  assign out_any   = out_any_reg;
  assign bit_count = count_reg;

endmodule

// File: tb/tb_serial_to_word.sv
// Directed testbench for serial_to_word. Two instances share the input
// stimulus: one MSB-first and one LSB-first, both WIDTH=8.
module tb_serial_to_word;

  logic       clock;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_m, out_valid_m, out_any_m;
  logic [7:0] out_data_m;
  logic [2:0] bit_count_m;

  logic       in_ready_l, out_valid_l, out_any_l;
  logic [7:0] out_data_l;
  logic [2:0] bit_count_l;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [7:0] xfer_data[$];
  int         xfer_cyc[$];

  serial_to_word #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .out_data  (out_data_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_any   (out_any_m),
    .bit_count (bit_count_m)
  );

  serial_to_word #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .out_data  (out_data_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_any   (out_any_l),
    .bit_count (bit_count_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record output transfers of the MSB-first instance (inputs settle at posedge+1,
  // so the negedge view equals what the next rising edge sees).
  always @(negedge clock) begin
    cyc++;
    if (out_valid_m && out_ready) begin
      xfer_data.push_back(out_data_m);
      xfer_cyc.push_back(cyc);
      $display("xfer: cycle %0d data 0x%02h", cyc, out_data_m);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_m); end
    checks++; if (out_data_m !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data_m); end
    checks++; if (out_any_m !== 1'b0) begin errors++; $display("FAIL reset_out_any: got %b want 0", out_any_m); end
    checks++; if (bit_count_m !== 3'd0) begin errors++; $display("FAIL reset_bit_count: got %0d want 0", bit_count_m); end
    checks++; if (in_ready_m !== 1'b1 || in_ready_l !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready_m, in_ready_l); end
    $display("test_reset done");
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    w = 8'hA5;
    out_ready = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL msb_early_valid: got %b want 0", out_valid_m); end
    checks++; if (bit_count_m !== 3'd7) begin errors++; $display("FAIL msb_count7: got %0d want 7", bit_count_m); end
    send_bit(w[0]);
    checks++; if (out_data_m !== 8'hA5) begin errors++; $display("FAIL msb_data: got %h want a5", out_data_m); end
    checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b want 1", out_valid_m); end
    checks++; if (out_any_m !== 1'b1) begin errors++; $display("FAIL msb_any: got %b want 1", out_any_m); end
    checks++; if (bit_count_m !== 3'd0) begin errors++; $display("FAIL msb_count_wrap: got %0d want 0", bit_count_m); end
    checks++; if (out_data_l !== 8'hA5 || out_valid_l !== 1'b1) begin errors++; $display("FAIL lsb_data_a5: got %h/%b want a5/1", out_data_l, out_valid_l); end
    tick();
    checks++; if (out_valid_m !== 1'b0 || out_data_m !== 8'hA5) begin errors++; $display("FAIL msb_drain: got valid %b data %h want 0/a5", out_valid_m, out_data_m); end
    $display("test_msb_first done");
  endtask

  task automatic test_lsb_zero();
    out_ready = 1'b1;
    send_word(8'hC0);  // bits 1,1,0,0,0,0,0,0
    checks++; if (out_data_m !== 8'hC0) begin errors++; $display("FAIL dir_msb: got %h want c0", out_data_m); end
    checks++; if (out_data_l !== 8'h03) begin errors++; $display("FAIL dir_lsb: got %h want 03", out_data_l); end
    send_word(8'h00);
    checks++; if (out_data_l !== 8'h00 || out_any_l !== 1'b0) begin errors++; $display("FAIL lsb_zero: got %h any %b want 00/0", out_data_l, out_any_l); end
    checks++; if (out_data_m !== 8'h00 || out_any_m !== 1'b0) begin errors++; $display("FAIL msb_zero: got %h any %b want 00/0", out_data_m, out_any_m); end
    checks++; if (out_valid_l !== 1'b1 || bit_count_l !== 3'd0) begin errors++; $display("FAIL lsb_zero_state: got %b/%0d want 1/0", out_valid_l, bit_count_l); end
    tick();
    $display("test_lsb_zero done");
  endtask

  task automatic test_backpressure();
    xfer_data.delete(); xfer_cyc.delete();
    out_ready = 1'b0;
    send_word(8'h3C);
    checks++; if (out_valid_m !== 1'b1 || out_data_m !== 8'h3C) begin errors++; $display("FAIL bp_first: got %b/%h want 1/3c", out_valid_m, out_data_m); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL bp_accept bit %0d: got in_ready %b want 1", i, in_ready_m); end
      send_bit(1'b1);
    end
    checks++; if (bit_count_m !== 3'd7) begin errors++; $display("FAIL bp_count: got %0d want 7", bit_count_m); end
    in_bit = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL bp_stall: got in_ready %b want 0", in_ready_m); end
    tick(); tick();
    checks++; if (out_data_m !== 8'h3C || out_valid_m !== 1'b1 || bit_count_m !== 3'd7) begin errors++; $display("FAIL bp_hold: got %h/%b/%0d want 3c/1/7", out_data_m, out_valid_m, bit_count_m); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready %b want 1", in_ready_m); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data_m !== 8'hFF || out_valid_m !== 1'b1 || bit_count_m !== 3'd0) begin errors++; $display("FAIL bp_replace: got %h/%b/%0d want ff/1/0", out_data_m, out_valid_m, bit_count_m); end
    tick();
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid_m); end
    checks++;
    if (xfer_data.size() != 2 || xfer_data[0] !== 8'h3C || xfer_data[1] !== 8'hFF) begin
      errors++; $display("FAIL bp_xfers: got %0d transfers want 2 (3c then ff)", xfer_data.size());
    end
    $display("test_backpressure done");
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'h81;
    xfer_data.delete(); xfer_cyc.delete();
    out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 6 || i == 2) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          checks++; if (bit_count_m !== 3'(8 - i)) begin errors++; $display("FAIL gap_hold: got %0d want %0d", bit_count_m, 8 - i); end
        end
      end
    end
    tick(); tick();
    checks++;
    if (xfer_data.size() != 1 || xfer_data[0] !== 8'h81) begin
      errors++; $display("FAIL gap_once: got %0d transfers want exactly one of 81", xfer_data.size());
    end
    $display("test_gapped done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'hF0;
    xfer_data.delete(); xfer_cyc.delete();
    out_ready = 1'b1;
    for (int i = 7; i >= 3; i--) send_bit(w[i]);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (bit_count_m !== 3'd0 || out_valid_m !== 1'b0 || out_data_m !== 8'h00) begin errors++; $display("FAIL midreset: got %0d/%b/%h want 0/0/00", bit_count_m, out_valid_m, out_data_m); end
    send_word(8'h5A);
    checks++; if (out_data_m !== 8'h5A || out_valid_m !== 1'b1) begin errors++; $display("FAIL midreset_word: got %h/%b want 5a/1", out_data_m, out_valid_m); end
    tick();
    checks++; if (xfer_data.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d transfers want 1", xfer_data.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    xfer_data.delete(); xfer_cyc.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL b2b_ready word %0d bit %0d: got %b want 1", k, i, in_ready_m); end
        send_bit(words[k][i]);
      end
    end
    tick(); tick();
    checks++;
    if (xfer_data.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d transfers want 3", xfer_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (xfer_data[k] !== words[k]) begin errors++; $display("FAIL b2b_data %0d: got %h want %h", k, xfer_data[k], words[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++; if (xfer_cyc[k] - xfer_cyc[k-1] != 8) begin errors++; $display("FAIL b2b_spacing %0d: got %0d want 8", k, xfer_cyc[k] - xfer_cyc[k-1]); end
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_zero();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
